// File: rtl/cv_tile_scheduler_if.sv
// Scheduler <-> loader/control bus: layer geometry in, tile requests and tile window out.
// The scheduler takes the master side.
interface cv_tile_scheduler_if;
    logic        start;
    logic [10:0] I;
    logic [10:0] O;
    logic [4:0]  K;
    logic [10:0] H;
    logic [10:0] W;
    logic [10:0] tile_o;
    logic [7:0]  tile_h;
    logic [7:0]  tile_w;
    logic        dl_lw_active;
    logic        dl_lif_active;
    logic        dl_sof_active;
    logic        dl_done;
    logic        load_weight;
    logic        load_input;
    logic        store_output;
    logic [10:0] Iori;
    logic [10:0] Oori;
    logic [10:0] Hori;
    logic [10:0] Wori;
    logic [10:0] Iext;
    logic [10:0] Oext;
    logic [10:0] Hext;
    logic [10:0] Wext;
    logic        busy;
    logic        done;
    logic [15:0] tile_cnt;

    modport master (
        input  start, I, O, K, H, W, tile_o, tile_h, tile_w,
               dl_lw_active, dl_lif_active, dl_sof_active, dl_done,
        output load_weight, load_input, store_output,
               Iori, Oori, Hori, Wori, Iext, Oext, Hext, Wext,
               busy, done, tile_cnt
    );

    modport slave (
        output start, I, O, K, H, W, tile_o, tile_h, tile_w,
               dl_lw_active, dl_lif_active, dl_sof_active, dl_done,
        input  load_weight, load_input, store_output,
               Iori, Oori, Hori, Wori, Iext, Oext, Hext, Wext,
               busy, done, tile_cnt
    );
endinterface

// File: rtl/cv_tile_scheduler.sv
// Convolution tile scheduler: walks output-channel, row, then column tiles and
// sequences weight-load / input-load / output-store requests to the data loader.
module cv_tile_scheduler (
    input  logic              clk,
    input  logic              rst,
    cv_tile_scheduler_if.master bus
);
    localparam int unsigned CW = 11;
    localparam int unsigned SW = 8;
    localparam int unsigned KW = 5;
    localparam int unsigned XW = 12;
    localparam int unsigned NW = 16;

    localparam logic [3:0] S_IDLE     = 4'd0;
    localparam logic [3:0] S_LW_REQ   = 4'd1;
    localparam logic [3:0] S_LW_WAIT  = 4'd2;
    localparam logic [3:0] S_LIF_REQ  = 4'd3;
    localparam logic [3:0] S_LIF_WAIT = 4'd4;
    localparam logic [3:0] S_SOF_REQ  = 4'd5;
    localparam logic [3:0] S_SOF_WAIT = 4'd6;
    localparam logic [3:0] S_NEXT     = 4'd7;
    localparam logic [3:0] S_FIN      = 4'd8;

    logic [3:0]    r_state, w_nxt_state;
    logic [CW-1:0] r_o, w_nxt_o, r_to, w_nxt_to;
    logic [KW-1:0] r_k, w_nxt_k;
    logic [SW-1:0] r_hout, w_nxt_hout, r_wout, w_nxt_wout;
    logic [SW-1:0] r_th, w_nxt_th, r_tw, w_nxt_tw;
    logic [CW-1:0] r_oori, w_nxt_oori, r_hori, w_nxt_hori, r_wori, w_nxt_wori;
    logic [CW-1:0] r_iext, w_nxt_iext, r_oext, w_nxt_oext;
    logic [CW-1:0] r_hext, w_nxt_hext, r_wext, w_nxt_wext;
    logic          r_lw, w_nxt_lw, r_lif, w_nxt_lif, r_sof, w_nxt_sof;
    logic          r_busy, w_nxt_busy, r_done, w_nxt_done;
    logic [NW-1:0] r_cnt, w_nxt_cnt;

    logic          w_upd_ext;
    logic [SW-1:0] w_hout_in, w_wout_in;
    logic [XW-1:0] w_wsum, w_hsum, w_osum;
    logic [XW-1:0] w_orem, w_hrem, w_wrem, w_hmin, w_wmin;

    // Next-state, tile walk and registered-output values
    always_comb begin
        w_nxt_state = r_state;
        w_nxt_o     = r_o;
        w_nxt_to    = r_to;
        w_nxt_k     = r_k;
        w_nxt_hout  = r_hout;
        w_nxt_wout  = r_wout;
        w_nxt_th    = r_th;
        w_nxt_tw    = r_tw;
        w_nxt_oori  = r_oori;
        w_nxt_hori  = r_hori;
        w_nxt_wori  = r_wori;
        w_nxt_iext  = r_iext;
        w_nxt_oext  = r_oext;
        w_nxt_hext  = r_hext;
        w_nxt_wext  = r_wext;
        w_nxt_cnt   = r_cnt;
        w_upd_ext   = 1'b0;
        w_hout_in   = SW'(XW'(bus.H) - XW'(bus.K) + XW'(1));
        w_wout_in   = SW'(XW'(bus.W) - XW'(bus.K) + XW'(1));
        w_wsum      = XW'(r_wori) + XW'(r_tw);
        w_hsum      = XW'(r_hori) + XW'(r_th);
        w_osum      = XW'(r_oori) + XW'(r_to);

        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_nxt_o     = bus.O;
                    w_nxt_k     = bus.K;
                    w_nxt_hout  = w_hout_in;
                    w_nxt_wout  = w_wout_in;
                    w_nxt_to    = (bus.tile_o == CW'(0)) ? bus.O     : bus.tile_o;
                    w_nxt_th    = (bus.tile_h == SW'(0)) ? w_hout_in : bus.tile_h;
                    w_nxt_tw    = (bus.tile_w == SW'(0)) ? w_wout_in : bus.tile_w;
                    w_nxt_oori  = '0;
                    w_nxt_hori  = '0;
                    w_nxt_wori  = '0;
                    w_nxt_iext  = bus.I;
                    w_nxt_cnt   = '0;
                    w_upd_ext   = 1'b1;
                    w_nxt_state = S_LW_REQ;
                end
            end
            S_LW_REQ:   if (bus.dl_lw_active)  w_nxt_state = S_LW_WAIT;
            S_LW_WAIT:  if (bus.dl_done)       w_nxt_state = S_LIF_REQ;
            S_LIF_REQ:  if (bus.dl_lif_active) w_nxt_state = S_LIF_WAIT;
            S_LIF_WAIT: if (bus.dl_done)       w_nxt_state = S_SOF_REQ;
            S_SOF_REQ:  if (bus.dl_sof_active) w_nxt_state = S_SOF_WAIT;
            S_SOF_WAIT: if (bus.dl_done)       w_nxt_state = S_NEXT;
            S_NEXT: begin
                w_nxt_cnt = r_cnt + NW'(1);
                w_upd_ext = 1'b1;
                if (w_wsum < XW'(r_wout)) begin
                    w_nxt_wori  = CW'(w_wsum);
                    w_nxt_state = S_LIF_REQ;
                end else begin
                    w_nxt_wori = '0;
                    if (w_hsum < XW'(r_hout)) begin
                        w_nxt_hori  = CW'(w_hsum);
                        w_nxt_state = S_LIF_REQ;
                    end else begin
                        w_nxt_hori = '0;
                        if (w_osum < XW'(r_o)) begin
                            w_nxt_oori  = CW'(w_osum);
                            w_nxt_state = S_LW_REQ;
                        end else begin
                            w_nxt_state = S_FIN;
                        end
                    end
                end
            end
            S_FIN:   w_nxt_state = S_IDLE;
            default: w_nxt_state = S_IDLE;
        endcase

        // Extents only move when the tile origin does, so they stay put across a request
        w_orem = XW'(w_nxt_o)    - XW'(w_nxt_oori);
        w_hrem = XW'(w_nxt_hout) - XW'(w_nxt_hori);
        w_wrem = XW'(w_nxt_wout) - XW'(w_nxt_wori);
        w_hmin = (XW'(w_nxt_th) < w_hrem) ? XW'(w_nxt_th) : w_hrem;
        w_wmin = (XW'(w_nxt_tw) < w_wrem) ? XW'(w_nxt_tw) : w_wrem;
        if (w_upd_ext) begin
            w_nxt_oext = (XW'(w_nxt_to) < w_orem) ? w_nxt_to : CW'(w_orem);
            w_nxt_hext = CW'(w_hmin + XW'(w_nxt_k) - XW'(1));
            w_nxt_wext = CW'(w_wmin + XW'(w_nxt_k) - XW'(1));
        end

        w_nxt_lw   = (w_nxt_state == S_LW_REQ);
        w_nxt_lif  = (w_nxt_state == S_LIF_REQ);
        w_nxt_sof  = (w_nxt_state == S_SOF_REQ);
        w_nxt_busy = (w_nxt_state != S_IDLE);
        w_nxt_done = (w_nxt_state == S_FIN);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_o     <= '0;
            r_to    <= '0;
            r_k     <= '0;
            r_hout  <= '0;
            r_wout  <= '0;
            r_th    <= '0;
            r_tw    <= '0;
            r_oori  <= '0;
            r_hori  <= '0;
            r_wori  <= '0;
            r_iext  <= '0;
            r_oext  <= '0;
            r_hext  <= '0;
            r_wext  <= '0;
            r_lw    <= 1'b0;
            r_lif   <= 1'b0;
            r_sof   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_nxt_state;
            r_o     <= w_nxt_o;
            r_to    <= w_nxt_to;
            r_k     <= w_nxt_k;
            r_hout  <= w_nxt_hout;
            r_wout  <= w_nxt_wout;
            r_th    <= w_nxt_th;
            r_tw    <= w_nxt_tw;
            r_oori  <= w_nxt_oori;
            r_hori  <= w_nxt_hori;
            r_wori  <= w_nxt_wori;
            r_iext  <= w_nxt_iext;
            r_oext  <= w_nxt_oext;
            r_hext  <= w_nxt_hext;
            r_wext  <= w_nxt_wext;
            r_lw    <= w_nxt_lw;
            r_lif   <= w_nxt_lif;
            r_sof   <= w_nxt_sof;
            r_busy  <= w_nxt_busy;
            r_done  <= w_nxt_done;
            r_cnt   <= w_nxt_cnt;
        end
    end

    assign bus.load_weight  = r_lw;
    assign bus.load_input   = r_lif;
    assign bus.store_output = r_sof;
    assign bus.Iori         = '0;
    assign bus.Oori         = r_oori;
    assign bus.Hori         = r_hori;
    assign bus.Wori         = r_wori;
    assign bus.Iext         = r_iext;
    assign bus.Oext         = r_oext;
    assign bus.Hext         = r_hext;
    assign bus.Wext         = r_wext;
    assign bus.busy         = r_busy;
    assign bus.done         = r_done;
    assign bus.tile_cnt     = r_cnt;
endmodule

// File: tb/tb_cv_tile_scheduler.sv
// Directed bench for cv_tile_scheduler with a small loader mock driven from the main sequence.
module tb_cv_tile_scheduler;
    logic clk;
    logic rst;
    int   checks;
    int   failures;

    cv_tile_scheduler_if bus ();

    cv_tile_scheduler dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic req_of(input int kind);
        case (kind)
            0:       return bus.load_weight;
            1:       return bus.load_input;
            default: return bus.store_output;
        endcase
    endfunction

    task automatic set_act(input int kind, input logic v);
        case (kind)
            0:       bus.dl_lw_active  = v;
            1:       bus.dl_lif_active = v;
            default: bus.dl_sof_active = v;
        endcase
    endtask

    task automatic set_geom(input int i, o, k, h, w, to, th, tw);
        bus.I      = 11'(i);
        bus.O      = 11'(o);
        bus.K      = 5'(k);
        bus.H      = 11'(h);
        bus.W      = 11'(w);
        bus.tile_o = 11'(to);
        bus.tile_h = 8'(th);
        bus.tile_w = 8'(tw);
    endtask

    task automatic pulse_start;
        bus.start = 1'b1;
        tick;
        bus.start = 1'b0;
    endtask

    // Serve one loader request: check the tile window, ack after dly cycles, then complete
    task automatic serve(input int kind, input int dly, input int eo, xo, eh, xh, ew, xw,
                         input bit inj_done, input bit inj_start);
        int n;
        n = 0;
        while (req_of(kind) !== 1'b1 && n < 40) begin
            tick;
            n++;
        end
        check($sformatf("req_rise_k%0d", kind), 32'(req_of(kind)), 32'd1);
        check("one_req", 32'(bus.load_weight) + 32'(bus.load_input) + 32'(bus.store_output), 32'd1);
        check("Oori", 32'(bus.Oori), 32'(eo));
        check("Oext", 32'(bus.Oext), 32'(xo));
        check("Hori", 32'(bus.Hori), 32'(eh));
        check("Hext", 32'(bus.Hext), 32'(xh));
        check("Wori", 32'(bus.Wori), 32'(ew));
        check("Wext", 32'(bus.Wext), 32'(xw));
        if (inj_done) begin
            bus.dl_done = 1'b1;
            tick;
            bus.dl_done = 1'b0;
            check("done_in_req_ignored", 32'(req_of(kind)), 32'd1);
        end
        for (int d = 0; d < dly; d++) begin
            tick;
            check("req_hold", 32'(req_of(kind)), 32'd1);
        end
        set_act(kind, 1'b1);
        tick;
        check("req_drop", 32'(req_of(kind)), 32'd0);
        bus.start = inj_start;
        tick;
        bus.start = 1'b0;
        bus.dl_done = 1'b1;
        tick;
        bus.dl_done = 1'b0;
        set_act(kind, 1'b0);
    endtask

    task automatic finish_layer(input int cnt);
        int n;
        n = 0;
        while (bus.done !== 1'b1 && n < 20) begin
            tick;
            n++;
        end
        check("done_rise", 32'(bus.done), 32'd1);
        check("tile_cnt", 32'(bus.tile_cnt), 32'(cnt));
        check("busy_in_fin", 32'(bus.busy), 32'd1);
        tick;
        check("done_pulse", 32'(bus.done), 32'd0);
        check("busy_idle", 32'(bus.busy), 32'd0);
    endtask

    // O=4 K=3 H=W=6 tiles 2/2/4: two channel tiles of two row tiles each
    task automatic run_basic(input bit perturb);
        for (int o = 0; o < 2; o++) begin
            serve(0, 0, 2*o, 2, 0, 4, 0, 6, 1'b0, 1'b0);
            if (perturb && o == 0) set_geom(9, 9, 1, 15, 15, 3, 3, 3);
            for (int h = 0; h < 2; h++) begin
                serve(1, 0, 2*o, 2, 2*h, 4, 0, 6, 1'b0, 1'b0);
                serve(2, 0, 2*o, 2, 2*h, 4, 0, 6, 1'b0, perturb && o == 0 && h == 0);
            end
        end
    endtask

    task automatic check_all_zero(input string pfx);
        check({pfx, "_lw"},   32'(bus.load_weight),  32'd0);
        check({pfx, "_lif"},  32'(bus.load_input),   32'd0);
        check({pfx, "_sof"},  32'(bus.store_output), 32'd0);
        check({pfx, "_busy"}, 32'(bus.busy),         32'd0);
        check({pfx, "_done"}, 32'(bus.done),         32'd0);
        check({pfx, "_cnt"},  32'(bus.tile_cnt),     32'd0);
        check({pfx, "_oori"}, 32'(bus.Oori),         32'd0);
        check({pfx, "_hori"}, 32'(bus.Hori),         32'd0);
        check({pfx, "_iext"}, 32'(bus.Iext),         32'd0);
        check({pfx, "_oext"}, 32'(bus.Oext),         32'd0);
        check({pfx, "_hext"}, 32'(bus.Hext),         32'd0);
        check({pfx, "_wext"}, 32'(bus.Wext),         32'd0);
    endtask

    initial begin
        int n;
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        bus.start         = 1'b0;
        bus.dl_lw_active  = 1'b0;
        bus.dl_lif_active = 1'b0;
        bus.dl_sof_active = 1'b0;
        bus.dl_done       = 1'b0;
        set_geom(2, 4, 3, 6, 6, 2, 2, 4);
        repeat (2) tick;
        check_all_zero("reset");
        rst = 1'b0;
        tick;
        check("idle_lw", 32'(bus.load_weight), 32'd0);

        // Basic walk; geometry changes and a stray start mid-layer must not disturb it
        bus.start = 1'b1;
        tick;
        bus.start = 1'b0;
        check("lw_latency", 32'(bus.load_weight), 32'd1);
        check("busy_run", 32'(bus.busy), 32'd1);
        check("Iori", 32'(bus.Iori), 32'd0);
        check("Iext", 32'(bus.Iext), 32'd2);
        run_basic(1'b1);
        finish_layer(4);
        check("oori_hold", 32'(bus.Oori), 32'd2);

        // Ragged edges: O=5 tile_o=2, H=7 tile_h=2 -> Hout=5
        set_geom(2, 5, 3, 7, 6, 2, 2, 4);
        pulse_start;
        for (int o = 0; o < 3; o++) begin
            serve(0, 0, 2*o, (o == 2) ? 1 : 2, 0, 4, 0, 6, 1'b0, 1'b0);
            for (int h = 0; h < 3; h++) begin
                serve(1, 0, 2*o, (o == 2) ? 1 : 2, 2*h, (h == 2) ? 3 : 4, 0, 6, 1'b0, 1'b0);
                serve(2, 0, 2*o, (o == 2) ? 1 : 2, 2*h, (h == 2) ? 3 : 4, 0, 6, 1'b0, 1'b0);
            end
        end
        finish_layer(9);

        // Whole-dimension tiles, slow weight ack, spurious done during input request
        set_geom(7, 3, 3, 8, 8, 0, 0, 0);
        pulse_start;
        check("Iext_whole", 32'(bus.Iext), 32'd7);
        serve(0, 5, 0, 3, 0, 8, 0, 8, 1'b0, 1'b0);
        serve(1, 0, 0, 3, 0, 8, 0, 8, 1'b1, 1'b0);
        serve(2, 0, 0, 3, 0, 8, 0, 8, 1'b0, 1'b0);
        finish_layer(1);

        // Reset in LIF_WAIT of the second channel tile, then a clean restart
        set_geom(2, 4, 3, 6, 6, 2, 2, 4);
        pulse_start;
        serve(0, 0, 0, 2, 0, 4, 0, 6, 1'b0, 1'b0);
        for (int h = 0; h < 2; h++) begin
            serve(1, 0, 0, 2, 2*h, 4, 0, 6, 1'b0, 1'b0);
            serve(2, 0, 0, 2, 2*h, 4, 0, 6, 1'b0, 1'b0);
        end
        serve(0, 0, 2, 2, 0, 4, 0, 6, 1'b0, 1'b0);
        n = 0;
        while (bus.load_input !== 1'b1 && n < 40) begin
            tick;
            n++;
        end
        check("pre_rst_lif", 32'(bus.load_input), 32'd1);
        check("pre_rst_oori", 32'(bus.Oori), 32'd2);
        bus.dl_lif_active = 1'b1;
        tick;
        check("pre_rst_wait", 32'(bus.load_input), 32'd0);
        rst = 1'b1;
        tick;
        rst = 1'b0;
        bus.dl_lif_active = 1'b0;
        check_all_zero("midrst");
        tick;
        check("post_rst_idle", 32'(bus.busy), 32'd0);
        pulse_start;
        check("restart_lw", 32'(bus.load_weight), 32'd1);
        run_basic(1'b0);
        finish_layer(4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/cv_tile_scheduler.md
Name: cv_tile_scheduler

Overview:
Upstream sequencer for the convolution data loader. On `start` it latches the layer geometry and walks the output feature map in tiles, in this order:
- output-channel tile, then row tile, then column tile;
- one weight load per output-channel tile;
- one input load plus one output store per spatial tile.

It drives the loader's tile origin/extent buses and its `load_weight`/`load_input`/`store_output` requests. It handshakes on the loader's activity flags and `done` pulse. Stride is 1, no padding, and input channels are not tiled.

Parameters:
- none (widths are fixed to match the loader buses)

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- start  input  1  one-cycle layer start; ignored unless idle
- I  input  11  input channels
- O  input  11  output channels
- K  input  5  kernel size
- H  input  11  input height
- W  input  11  input width
- tile_o  input  11  output channels per tile; 0 = whole O
- tile_h  input  8  output rows per tile; 0 = whole Hout
- tile_w  input  8  output cols per tile; 0 = whole Wout
- dl_lw_active  input  1  loader is in weight-load state
- dl_lif_active  input  1  loader is in input-load state
- dl_sof_active  input  1  loader is in output-store state
- dl_done  input  1  loader completion pulse
- load_weight  output  1  weight-load request
- load_input  output  1  input-load request
- store_output  output  1  output-store request
- Iori  output  11  input-channel origin
- Oori  output  11  output-channel origin
- Hori  output  11  tile row origin
- Wori  output  11  tile column origin
- Iext  output  11  input-channel extent
- Oext  output  11  output-channel extent
- Hext  output  11  input rows for the tile
- Wext  output  11  input cols for the tile
- busy  output  1  high when not IDLE
- done  output  1  one-cycle pulse at layer end
- tile_cnt  output  16  spatial tiles completed this layer

Behaviour:
- Reset: state IDLE. All outputs 0, all counters 0. Reset mid-layer aborts immediately; no request stays asserted.
- Derived values, computed at start and then held:
  - Hout = H-K+1, Wout = W-K+1 (8-bit).
  - A zero tile size is replaced by the full dimension.
  - Geometry inputs are latched on start; later changes are ignored until the next start.
- Extents:
  - Iori=0, Iext=I always.
  - Oext = min(tile_o, O-Oori).
  - Hext = min(tile_h, Hout-Hori)+K-1.
  - Wext = min(tile_w, Wout-Wori)+K-1.
  - Origins and extents are registered and stable from the cycle a request rises until the store's dl_done.
- States: IDLE, LW_REQ, LW_WAIT, LIF_REQ, LIF_WAIT, SOF_REQ, SOF_WAIT, NEXT, FIN.
- IDLE:
  - start -> LW_REQ, with Oori=Hori=Wori=0 and tile_cnt=0.
  - load_weight is high from the next cycle (1-cycle latency).
- Request/wait pairs (LW/dl_lw_active, LIF/dl_lif_active, SOF/dl_sof_active):
  - In X_REQ the request is held high until the matching active flag is sampled high.
  - The request then drops on the next clock edge and the state moves to X_WAIT.
  - In X_WAIT, dl_done moves LW_WAIT->LIF_REQ, LIF_WAIT->SOF_REQ, SOF_WAIT->NEXT.
  - At most one request is high at any time.
- dl_done seen in any REQ state is ignored. If dl_done and the active flag arrive in the same cycle in a REQ state, the ack takes priority.
- NEXT (one cycle), tile_cnt+1, then:
  - If Wori+tile_w < Wout: Wori += tile_w -> LIF_REQ.
  - Else Wori=0. If Hori+tile_h < Hout: Hori += tile_h -> LIF_REQ.
  - Else Hori=0. If Oori+tile_o < O: Oori += tile_o -> LW_REQ.
  - Else -> FIN.
- Comparisons are done in 12 bits so the sums never wrap.
- FIN: done=1 for one cycle -> IDLE. Origins hold their last values and busy drops with the return to IDLE.
- start while busy: ignored, with no effect on any counter.

Test Plan:
- O=4, I=2, K=3, H=W=6, tile_o=2, tile_h=2, tile_w=4 -> Hout=Wout=4:
  - Sequence is LW, (LIF,SOF)x2, LW, (LIF,SOF)x2.
  - First tile: Oori=0, Oext=2, Hori=0, Hext=4, Wori=0, Wext=6.
  - Second tile: Hori=2.
  - Ends with tile_cnt=4 and one done pulse.
- O=5, tile_o=2 (other sizes as above) -> third weight load has Oori=4, Oext=1. H=7 with tile_h=2 -> Hout=5, last row tile Hori=4, Hext=3.
- tile_o=tile_h=tile_w=0, O=3, H=W=8, K=3:
  - Exactly one LW/LIF/SOF.
  - Oext=3, Hext=Wext=8.
  - tile_cnt=1, done pulse.
- Loader mock delays the active flag by 5 cycles -> load_weight stays high for all 5 cycles and drops one cycle after the ack. A dl_done injected during LIF_REQ is ignored.
- start pulsed during SOF_WAIT -> no effect; run completes with the expected tile_cnt.
- rst asserted in LIF_WAIT -> next cycle all outputs 0, busy=0. A fresh start then restarts from Oori=0.
